// File: rtl/mode_arb_pkg.sv
// Shared types, default sizing and helpers for the mode register arbiter.
// Optional fixed priority for requester 0 is enabled with MODE_ARB_PRIO_EN.
package mode_arb_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 2;
    localparam int unsigned HOLD_DEF  = 3;

    typedef enum logic {
        StIdle,
        StHold
    } arb_state_e;

    // Supports up to 8 requesters; the highest set bit wins on a malformed input.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after the last winner,
// wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int cand;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = (int'(last) + k) % int'(N);
            if (req[IW'(cand)]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mode_reg_arbiter.sv
// Round-robin arbiter sequencing writes from NREQ requesters into one shared mode
// register. Define MODE_ARB_PRIO_EN to give requester 0 fixed top priority.
module mode_reg_arbiter
    import mode_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned HOLD  = HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  ack,
    output logic [WIDTH-1:0]      mode,
    output logic                  busy,
    output logic                  mode_all_ones
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(HOLD + 1);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    last_q, last_d;

    logic [NREQ-1:0]  rr_req;
    logic [IW-1:0]    rr_idx;
    logic             rr_valid;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             win_req;
    logic [7:0]       gnt_ext;
    logic [IW-1:0]    win_idx;

`ifdef MODE_ARB_PRIO_EN
    // Requester 0 bypasses the ring; the others rotate among themselves.
    always_comb begin
        rr_req     = req & ~NREQ'(1);
        pick_valid = req[0] | rr_valid;
        pick_idx   = req[0] ? '0 : rr_idx;
    end
`else
    always_comb begin
        rr_req     = req;
        pick_valid = rr_valid;
        pick_idx   = rr_idx;
    end
`endif

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (rr_req),
        .last  (last_q),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    always_comb begin
        gnt_ext             = '0;
        gnt_ext[NREQ-1:0]   = gnt_q;
    end

    assign win_idx = IW'(onehot_to_idx(gnt_ext));
    assign win_req = |(req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = NREQ'(1) << pick_idx;
                    mode_d  = wdata[pick_idx*WIDTH +: WIDTH];
                    ack_d   = 1'b1;
                    cnt_d   = CW'(HOLD - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!win_req || cnt_q == '0) begin
                    gnt_d   = '0;
                    state_d = StIdle;
`ifdef MODE_ARB_PRIO_EN
                    if (!gnt_q[0]) last_d = win_idx;
`else
                    last_d = win_idx;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt           = gnt_q;
    assign ack           = ack_q;
    assign mode          = mode_q;
    assign busy          = (state_q == StHold);
    assign mode_all_ones = &mode_q;

endmodule

// File: tb/tb_mode_reg_arbiter.sv
// Self-checking bench for mode_reg_arbiter: directed scenarios plus random traffic
// against a grant-length reference model. Honours MODE_ARB_PRIO_EN when defined.
module tb_mode_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int HOLD  = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  ack;
    logic [WIDTH-1:0]      mode;
    logic                  busy;
    logic                  mode_all_ones;

    always #5 clk = ~clk;

    mode_reg_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .wdata         (wdata),
        .gnt           (gnt),
        .ack           (ack),
        .mode          (mode),
        .busy          (busy),
        .mode_all_ones (mode_all_ones)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current winner (-1 when idle) and how long it has held.
    int m_win, m_len, m_last, m_mode, m_ack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win  = -1;
        m_len  = 0;
        m_last = NREQ - 1;
        m_mode = 0;
        m_ack  = 0;
    endtask

    task automatic model_step();
        int w;
        int c;
        m_ack = 0;
        if (m_win < 0) begin
            w = -1;
`ifdef MODE_ARB_PRIO_EN
            if (req[0]) w = 0;
`endif
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) begin
                m_win  = w;
                m_len  = 1;
                m_mode = int'(wdata[w*WIDTH +: WIDTH]);
                m_ack  = 1;
            end
        end else if (!req[m_win] || m_len == HOLD) begin
`ifdef MODE_ARB_PRIO_EN
            if (m_win != 0) m_last = m_win;
`else
            m_last = m_win;
`endif
            m_win = -1;
        end else begin
            m_len++;
        end
    endtask

    task automatic compare_all();
        check_eq("gnt", 32'(gnt), (m_win < 0) ? 32'd0 : (32'd1 << m_win));
        check_eq("ack", 32'(ack), 32'(m_ack));
        check_eq("mode", 32'(mode), 32'(m_mode));
        check_eq("busy", 32'(busy), (m_win < 0) ? 32'd0 : 32'd1);
        check_eq("mode_all_ones", 32'(mode_all_ones), (m_mode == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        #1;
        reset = 1'b1;
    endtask

    int exp_t1_gnt [5] = '{1, 1, 1, 0, 1};
    int exp_t1_ack [5] = '{1, 0, 0, 0, 1};
    int exp_t2_mode[5];
    int t2_modes[$];

    initial begin
        reset = 1'b0;
        req   = '0;
        wdata = '0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b1;

        // Single requester holding req: 3-cycle grant, one bubble, re-grant.
        req   = 4'b0001;
        wdata = 8'h03;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t1_gnt", 32'(gnt), 32'(exp_t1_gnt[i]));
            check_eq("t1_ack", 32'(ack), 32'(exp_t1_ack[i]));
        end
        check_eq("t1_all_ones", 32'(mode_all_ones), 32'd1);

        // All requesting: rotation 0,1,2,3,0 with mode tracking the winner.
        @(negedge clk);
        pulse_reset();
        req   = 4'b1111;
        wdata = 8'he4;
`ifdef MODE_ARB_PRIO_EN
        exp_t2_mode = '{0, 0, 0, 0, 0};
`else
        exp_t2_mode = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ack) t2_modes.push_back(int'(mode));
        end
        check_eq("t2_grants", 32'(t2_modes.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < t2_modes.size()) check_eq("t2_order", 32'(t2_modes[i]), 32'(exp_t2_mode[i]));
        end

        // wdata change during HOLD must not reach mode.
        req = 4'b0000;
        for (int i = 0; i < 4; i++) cycle();
        req   = 4'b0010;
        wdata = 8'h04;
        cycle();
        wdata = 8'h08;
        cycle();
        check_eq("t6_mode", 32'(mode), 32'd1);
        check_eq("t6_ack", 32'(ack), 32'd0);
        req = 4'b0000;
        cycle();

        // Random traffic with occasional mid-grant resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
            wdata = (NREQ*WIDTH)'($urandom);
            cycle();
            if ($urandom_range(0, 79) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mode_reg_arbiter.md
Name: mode_reg_arbiter

Overview:
Shares a single WIDTH-bit mode register between NREQ requesters.
- Requesters raise req with a proposed value on wdata.
- The arbiter picks one winner round-robin, loads its value into the shared register and holds the grant for up to HOLD cycles.
- Sits in front of the small mode/state registers in the test designs and sequences all writes to them. mode_all_ones flags the mode == all-ones condition for the property checker.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 2, width of the shared mode register
HOLD, 3, maximum grant length in cycles (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request, level
wdata  input  NREQ*WIDTH  proposed mode per requester; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
ack  output  1  one-cycle pulse: mode was loaded this cycle
mode  output  WIDTH  shared mode register
busy  output  1  high while in HOLD state
mode_all_ones  output  1  combinational AND-reduce of mode

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; gnt=0, ack=0, mode=0, busy=0.
  - last winner pointer = NREQ-1, so requester 0 wins first after reset.
  - Hold count = 0.
- FSM states: IDLE, HOLD.
- IDLE, req==0: stay; outputs unchanged except ack=0.
- IDLE, req!=0, at the clock edge:
  - Winner w = first set req bit scanning last+1, last+2, ... modulo NREQ.
  - gnt<=onehot(w); mode<=wdata[w]; ack<=1; cnt<=HOLD-1; state<=HOLD; busy<=1.
- Latency: req sampled at edge k -> gnt, mode, ack visible after edge k; ack lasts exactly one cycle.
- HOLD, each edge:
  - ack<=0.
  - If req[w]==0 or cnt==0: release. gnt<=0, busy<=0, last<=w, state<=IDLE.
  - Otherwise cnt<=cnt-1.
- Resulting grant lengths:
  - Maximum HOLD cycles; HOLD==1 gives single-cycle grants.
  - Early release when the winner drops req; minimum 1 cycle.
- Mandatory IDLE bubble of one cycle between consecutive grants. gnt is never high in two back-to-back grants without a gap.
- mode changes only on the IDLE->HOLD edge. wdata changes during HOLD are ignored.
- Only req bits are arbitrated. wdata of non-requesters is don't-care.
- Simultaneous requests: exactly one winner. The next winner is searched starting after the previous winner, so no requester starves. Worst-case wait is (NREQ-1)*(HOLD+1) cycles.
- Reset asserted mid-grant: everything returns to reset values immediately, including mode=0 and pointer=NREQ-1.
- cnt width = $clog2(HOLD+1). No arithmetic wrap: cnt never decrements below 0.

Optional Feature:
Macro MODE_ARB_PRIO_EN.
- Defined: requester 0 has fixed top priority. In IDLE, req[0]==1 always wins regardless of pointer. The remaining requesters are round-robin among themselves. A requester-0 win does not update last.
- Undefined: pure round-robin across all NREQ requesters as above.
- No preemption of an active grant in either case.

Decomposition:
- Package mode_arb_pkg:
  - FSM state typedef (IDLE, HOLD).
  - Default constants for NREQ, WIDTH, HOLD.
  - Function onehot-to-index.
- One combinational sub-module rr_pick:
  - Inputs: req and last pointer.
  - Outputs: winner index and valid.
  - Reused by other arbiters in the test designs.
- The FSM, counter and mode register stay in mode_reg_arbiter.

Test Plan:
1. Reset, then req=4'b0001, wdata[0]=2'd3 held 5 cycles -> gnt=0001 for 3 cycles; ack one pulse; mode=3; mode_all_ones=1; then 1 IDLE cycle; then gnt=0001 again with ack.
2. req=4'b1111 constant, wdata=i per requester, HOLD=3 -> grants 0,1,2,3,0 in order, each 3 cycles plus 1 gap; mode follows 0,1,2,3.
3. Winner 2 granted, drops req after 1 cycle -> gnt cleared on the next edge; busy=0; next grant goes to requester 3 if requesting.
4. Reset pulled low mid-HOLD with mode=2 -> gnt=0, mode=0, busy=0 immediately. After release, req=4'b1000 gives gnt=1000.
5. MODE_ARB_PRIO_EN defined, req=4'b0101 constant -> requester 0 wins every grant. With it undefined, grants alternate 0,2,0,2.
6. wdata[w] changed from 1 to 2 during HOLD -> mode stays 1; ack does not re-pulse.
